// File: rtl/interrupt_sequencer.sv
// 6502 interrupt sequencer: arbitrates RESET/NMI/BRK/IRQ at instruction boundaries and
// drives the stack-push / vector-fetch cycles onto the shared memory and register-file datapath.
module interrupt_sequencer #(
    parameter logic [15:0] VEC_NMI    = 16'hFFFA,
    parameter logic [15:0] VEC_RESET  = 16'hFFFC,
    parameter logic [15:0] VEC_IRQ    = 16'hFFFE,
    parameter logic [7:0]  STACK_PAGE = 8'h01
) (
    input  logic        clk,
    input  logic        rst_x,
    input  logic        irq_x,
    input  logic        nmi_x,
    input  logic        brk,
    input  logic        boundary,
    input  logic        i_flag,
    input  logic [7:0]  rgf_s,
    input  logic [7:0]  rgf_psr,
    input  logic [15:0] rgf_pc,
    input  logic [7:0]  mem_data_in,
    output logic [15:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [7:0]  mem_data_out,
    output logic [7:0]  rgf_data,
    output logic        rgf_set_pcl,
    output logic        rgf_set_pch,
    output logic        rgf_set_i,
    output logic        rgf_s_dec,
    output logic        busy,
    output logic        ack
);

    typedef enum logic [3:0] {
        ST_RST0   = 4'd0,
        ST_RST1   = 4'd1,
        ST_RST2   = 4'd2,
        ST_VEC_LO = 4'd3,
        ST_VEC_HI = 4'd4,
        ST_IDLE   = 4'd5,
        ST_PUSH_H = 4'd6,
        ST_PUSH_L = 4'd7,
        ST_PUSH_P = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        SRC_RESET = 2'd0,
        SRC_NMI   = 2'd1,
        SRC_BRK   = 2'd2,
        SRC_IRQ   = 2'd3
    } src_t;

    state_t      state_r;
    src_t        src_r;
    logic        nmi_pend_r;
    logic        nmi_prev_r;
    logic        hold_r;
    logic [15:0] vec_r;
    logic        nmi_edge_s;
    logic [15:0] vec_sel_s;

    // Stacked status byte: bit 5 always set, B reflects whether a BRK started the sequence.
    function automatic logic [7:0] stacked_psr(input logic [7:0] p, input logic b);
        return {p[7:6], 1'b1, b, p[3:0]};
    endfunction

    assign nmi_edge_s = nmi_prev_r & ~nmi_x;

    // Vector selection; a pending NMI overrides BRK/IRQ up to the vector-low cycle.
    always_comb begin
        vec_sel_s = VEC_IRQ;
        if (src_r == SRC_RESET) begin
            vec_sel_s = VEC_RESET;
        end else if (nmi_pend_r) begin
            vec_sel_s = VEC_NMI;
        end else begin
            vec_sel_s = VEC_IRQ;
        end
    end

    // Sequencer state, source latch and NMI edge bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_x) begin
            state_r    <= ST_RST0;
            src_r      <= SRC_RESET;
            nmi_pend_r <= 1'b0;
            hold_r     <= 1'b1;
            vec_r      <= VEC_RESET;
            nmi_prev_r <= nmi_x;
        end else begin
            hold_r     <= 1'b0;
            nmi_prev_r <= nmi_x;
            // A fresh edge wins over consumption so an NMI in the selection cycle is not lost.
            if (nmi_edge_s) begin
                nmi_pend_r <= 1'b1;
            end else if (state_r == ST_VEC_LO && src_r != SRC_RESET && nmi_pend_r) begin
                nmi_pend_r <= 1'b0;
            end else begin
                nmi_pend_r <= nmi_pend_r;
            end

            if (hold_r) begin
                state_r <= ST_RST0;
            end else begin
                case (state_r)
                    ST_RST0:   state_r <= ST_RST1;
                    ST_RST1:   state_r <= ST_RST2;
                    ST_RST2:   state_r <= ST_VEC_LO;
                    ST_PUSH_H: state_r <= ST_PUSH_L;
                    ST_PUSH_L: state_r <= ST_PUSH_P;
                    ST_PUSH_P: state_r <= ST_VEC_LO;
                    ST_VEC_LO: begin
                        vec_r   <= vec_sel_s;
                        state_r <= ST_VEC_HI;
                    end
                    ST_VEC_HI: state_r <= ST_IDLE;
                    ST_IDLE: begin
                        if (boundary && nmi_pend_r) begin
                            src_r   <= SRC_NMI;
                            state_r <= ST_PUSH_H;
                        end else if (boundary && brk) begin
                            src_r   <= SRC_BRK;
                            state_r <= ST_PUSH_H;
                        end else if (boundary && !irq_x && !i_flag) begin
                            src_r   <= SRC_IRQ;
                            state_r <= ST_PUSH_H;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    default: state_r <= ST_IDLE;
                endcase
            end
        end
    end

    // Moore decode of the bus and register-file controls; silent while reset is held.
    always_comb begin
        mem_addr     = 16'h0000;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_data_out = 8'h00;
        rgf_data     = 8'h00;
        rgf_set_pcl  = 1'b0;
        rgf_set_pch  = 1'b0;
        rgf_set_i    = 1'b0;
        rgf_s_dec    = 1'b0;
        busy         = 1'b0;
        ack          = 1'b0;
        if (hold_r) begin
            busy = 1'b0;
        end else begin
            case (state_r)
                ST_RST0, ST_RST1, ST_RST2: begin
                    mem_read  = 1'b1;
                    mem_addr  = {STACK_PAGE, rgf_s};
                    rgf_s_dec = 1'b1;
                    busy      = 1'b1;
                end
                ST_PUSH_H: begin
                    mem_write    = 1'b1;
                    mem_addr     = {STACK_PAGE, rgf_s};
                    mem_data_out = rgf_pc[15:8];
                    rgf_s_dec    = 1'b1;
                    busy         = 1'b1;
                end
                ST_PUSH_L: begin
                    mem_write    = 1'b1;
                    mem_addr     = {STACK_PAGE, rgf_s};
                    mem_data_out = rgf_pc[7:0];
                    rgf_s_dec    = 1'b1;
                    busy         = 1'b1;
                end
                ST_PUSH_P: begin
                    mem_write    = 1'b1;
                    mem_addr     = {STACK_PAGE, rgf_s};
                    mem_data_out = stacked_psr(rgf_psr, src_r == SRC_BRK);
                    rgf_s_dec    = 1'b1;
                    busy         = 1'b1;
                end
                ST_VEC_LO: begin
                    mem_read    = 1'b1;
                    mem_addr    = vec_sel_s;
                    rgf_data    = mem_data_in;
                    rgf_set_pcl = 1'b1;
                    rgf_set_i   = 1'b1;
                    busy        = 1'b1;
                end
                ST_VEC_HI: begin
                    mem_read    = 1'b1;
                    mem_addr    = vec_r + 16'd1;
                    rgf_data    = mem_data_in;
                    rgf_set_pch = 1'b1;
                    ack         = 1'b1;
                    busy        = 1'b1;
                end
                ST_IDLE: busy = 1'b0;
                default: busy = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: directed scenarios plus randomized BRK/IRQ/NMI
// sequences compared cycle by cycle against an abstract per-cycle bus model.
module tb_interrupt_sequencer;

    localparam int K_RESET = 0;
    localparam int K_NMI   = 1;
    localparam int K_BRK   = 2;
    localparam int K_IRQ   = 3;

    typedef struct packed {
        logic [15:0] addr;
        logic        rd;
        logic        wr;
        logic [7:0]  dout;
        logic [7:0]  rdata;
        logic        pcl;
        logic        pch;
        logic        seti;
        logic        sdec;
        logic        busy;
        logic        ack;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst_x = 1'b0;
    logic        irq_x = 1'b1;
    logic        nmi_x = 1'b1;
    logic        brk = 1'b0;
    logic        boundary = 1'b0;
    logic        i_flag = 1'b0;
    logic [7:0]  rgf_s;
    logic [7:0]  rgf_psr = 8'h00;
    logic [15:0] rgf_pc;
    logic [7:0]  mem_data_in;
    logic [15:0] mem_addr;
    logic        mem_read, mem_write;
    logic [7:0]  mem_data_out, rgf_data;
    logic        rgf_set_pcl, rgf_set_pch, rgf_set_i, rgf_s_dec, busy, ack;

    logic        ld_en = 1'b0;
    logic [7:0]  ld_s = 8'h00;
    logic [15:0] ld_pc = 16'h0000;
    logic [7:0]  vlo = 8'h00;
    logic [7:0]  vhi = 8'h00;

    int vectors = 0;
    int miscompares = 0;

    interrupt_sequencer dut (
        .clk(clk), .rst_x(rst_x), .irq_x(irq_x), .nmi_x(nmi_x), .brk(brk),
        .boundary(boundary), .i_flag(i_flag), .rgf_s(rgf_s), .rgf_psr(rgf_psr),
        .rgf_pc(rgf_pc), .mem_data_in(mem_data_in), .mem_addr(mem_addr),
        .mem_read(mem_read), .mem_write(mem_write), .mem_data_out(mem_data_out),
        .rgf_data(rgf_data), .rgf_set_pcl(rgf_set_pcl), .rgf_set_pch(rgf_set_pch),
        .rgf_set_i(rgf_set_i), .rgf_s_dec(rgf_s_dec), .busy(busy), .ack(ack)
    );

    always #5 clk = ~clk;

    // Vector ROM: odd addresses return the high byte, even the low byte.
    assign mem_data_in = mem_addr[0] ? vhi : vlo;

    // Register-file model: reacts to the sequencer's S and PC controls.
    always @(posedge clk) begin
        if (ld_en) begin
            rgf_s  <= ld_s;
            rgf_pc <= ld_pc;
        end else begin
            if (rgf_s_dec)   rgf_s <= rgf_s - 8'd1;
            if (rgf_set_pcl) rgf_pc[7:0] <= rgf_data;
            if (rgf_set_pch) rgf_pc[15:8] <= rgf_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] s, input logic [15:0] pc);
        ld_s  = s;
        ld_pc = pc;
        ld_en = 1'b1;
        tick();
        ld_en = 1'b0;
    endtask

    function automatic bus_t observe();
        bus_t o;
        o = {mem_addr, mem_read, mem_write, mem_data_out, rgf_data,
             rgf_set_pcl, rgf_set_pch, rgf_set_i, rgf_s_dec, busy, ack};
        return o;
    endfunction

    // Cycle i of a service sequence: three stack cycles, then the two vector bytes.
    function automatic bus_t exp_cycle(input int kind, input int i, input logic [7:0] s0,
                                       input logic [15:0] pc, input logic [7:0] psr,
                                       input logic [15:0] vec, input logic [7:0] lo,
                                       input logic [7:0] hi);
        bus_t e;
        logic [7:0] sp;
        e = '0;
        sp = s0 - 8'(i);
        if (i < 3) begin
            e.addr = {8'h01, sp};
            e.sdec = 1'b1;
            e.busy = 1'b1;
            if (kind == K_RESET) begin
                e.rd = 1'b1;
            end else begin
                e.wr = 1'b1;
                if (i == 0)      e.dout = pc[15:8];
                else if (i == 1) e.dout = pc[7:0];
                else             e.dout = (psr & 8'hCF) | 8'h20 | ((kind == K_BRK) ? 8'h10 : 8'h00);
            end
        end else if (i == 3) begin
            e.addr = vec; e.rd = 1'b1; e.rdata = lo; e.pcl = 1'b1; e.seti = 1'b1; e.busy = 1'b1;
        end else begin
            e.addr = vec + 16'd1; e.rd = 1'b1; e.rdata = hi; e.pch = 1'b1; e.ack = 1'b1; e.busy = 1'b1;
        end
        return e;
    endfunction

    task automatic cmp_bus(input bus_t exp, input string tag);
        bus_t got;
        got = observe();
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h required %h", tag, got, exp);
        end
    endtask

    task automatic cmp_pc(input logic [15:0] exp, input string tag);
        vectors++;
        assert (rgf_pc === exp) else begin
            miscompares++;
            $error("FAIL %s: observed pc %h required %h", tag, rgf_pc, exp);
        end
    endtask

    // Entered in the first cycle of a sequence; nmi_at/abort_at pick a cycle for an NMI edge or reset.
    task automatic run_seq(input int kind, input int nmi_at, input int abort_at,
                           input logic [15:0] vec, input string name);
        logic [7:0]  s0;
        logic [15:0] pc0;
        logic [7:0]  psr0;
        s0   = rgf_s;
        pc0  = rgf_pc;
        psr0 = rgf_psr;
        for (int i = 0; i < 5; i++) begin
            cmp_bus(exp_cycle(kind, i, s0, pc0, psr0, vec, vlo, vhi), $sformatf("%s c%0d", name, i));
            if (nmi_at == 4 && i == 3) nmi_x = 1'b1;
            if (i == nmi_at) nmi_x = 1'b0;
            if (i == abort_at) begin
                rst_x = 1'b0;
                tick();
                cmp_bus('0, $sformatf("%s abort", name));
                tick();
                cmp_bus('0, $sformatf("%s abort hold", name));
                return;
            end
            if (i == 4) begin
                brk = 1'b0;
                irq_x = 1'b1;
                boundary = 1'b0;
            end
            tick();
        end
        cmp_bus('0, $sformatf("%s idle", name));
        cmp_pc({vhi, vlo}, $sformatf("%s pc", name));
        if (nmi_at >= 0) begin
            nmi_x = 1'b1;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish within time limit");
        $fatal(1);
    end

    initial begin
        // Reset release with S=$00: stack reads wrap through $0100,$01FF,$01FE.
        tick();
        tick();
        load(8'h00, 16'h0000);
        cmp_bus('0, "in_reset");
        vlo = 8'h89;
        vhi = 8'h89;
        rst_x = 1'b1;
        tick();
        run_seq(K_RESET, -1, -1, 16'hFFFC, "reset");

        // Unmasked IRQ.
        load(8'hFD, 16'h1234);
        rgf_psr = 8'h00;
        vlo = 8'h00; vhi = 8'hC0;
        irq_x = 1'b0; i_flag = 1'b0; boundary = 1'b1;
        cmp_bus('0, "irq req");
        tick();
        run_seq(K_IRQ, -1, -1, 16'hFFFE, "irq");

        // Masked IRQ never starts a sequence.
        irq_x = 1'b0; i_flag = 1'b1; boundary = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            cmp_bus('0, $sformatf("masked c%0d", i));
        end
        irq_x = 1'b1; i_flag = 1'b0; boundary = 1'b0;
        tick();

        // BRK, then BRK hijacked by an NMI edge in the PUSH_L cycle.
        load(8'h80, 16'hABCD);
        vlo = 8'h11; vhi = 8'h22;
        brk = 1'b1; boundary = 1'b1;
        tick();
        run_seq(K_BRK, -1, -1, 16'hFFFE, "brk");
        load(8'h01, 16'h4321);
        vlo = 8'h33; vhi = 8'h44;
        brk = 1'b1; boundary = 1'b1;
        tick();
        run_seq(K_BRK, 1, -1, 16'hFFFA, "brk_hijack");

        // NMI held low across many boundaries: one sequence only.
        load(8'h40, 16'h5555);
        vlo = 8'h55; vhi = 8'h66;
        nmi_x = 1'b0; boundary = 1'b1;
        tick();
        cmp_bus('0, "nmi edge");
        tick();
        run_seq(K_NMI, -1, -1, 16'hFFFA, "nmi");
        boundary = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            cmp_bus('0, $sformatf("nmi_level c%0d", i));
        end
        // Second edge during VEC_HI is served at the next boundary.
        nmi_x = 1'b1;
        tick();
        nmi_x = 1'b0;
        tick();
        cmp_bus('0, "nmi2 edge");
        tick();
        run_seq(K_NMI, 4, -1, 16'hFFFA, "nmi2");
        vlo = 8'h77; vhi = 8'h88;
        boundary = 1'b1;
        tick();
        run_seq(K_NMI, -1, -1, 16'hFFFA, "nmi3");

        // Reset asserted during PUSH_L aborts the sequence; reset sequence follows.
        load(8'hF0, 16'h9999);
        brk = 1'b1; boundary = 1'b1;
        tick();
        run_seq(K_BRK, -1, 1, 16'hFFFE, "abort");
        brk = 1'b0; boundary = 1'b0;
        vlo = 8'h12; vhi = 8'h34;
        rst_x = 1'b1;
        tick();
        run_seq(K_RESET, -1, -1, 16'hFFFC, "reset2");

        // Randomized BRK/IRQ with optional NMI edge at a random cycle.
        for (int n = 0; n < 40; n++) begin
            int kind;
            int r;
            int nmi_at;
            kind = ($urandom_range(0, 1) == 0) ? K_BRK : K_IRQ;
            r = $urandom_range(0, 5);
            nmi_at = (r == 5) ? -1 : r;
            load(8'($urandom), 16'($urandom));
            rgf_psr = 8'($urandom);
            vlo = 8'($urandom);
            vhi = 8'($urandom);
            if (kind == K_BRK) brk = 1'b1;
            else begin irq_x = 1'b0; i_flag = 1'b0; end
            boundary = 1'b1;
            cmp_bus('0, $sformatf("rnd%0d req", n));
            tick();
            run_seq(kind, nmi_at, -1, (nmi_at >= 0 && nmi_at <= 2) ? 16'hFFFA : 16'hFFFE,
                    $sformatf("rnd%0d", n));
            if (nmi_at >= 3) begin
                vlo = 8'($urandom);
                vhi = 8'($urandom);
                boundary = 1'b1;
                tick();
                run_seq(K_NMI, -1, -1, 16'hFFFA, $sformatf("rnd%0d nmi", n));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
